// File: rtl/road_det_qualifier.sv
// Vehicle-loop conditioner: synchronises and glitch-filters ROAD_DET, then derives presence,
// arrival pulses, a road-gap flag, a stuck-loop fault and a saturating arrival count.
module road_det_qualifier #(
  parameter int unsigned FILT_CYCLES  = 50000,
  parameter int unsigned GAP_CYCLES   = 150000,
  parameter int unsigned STUCK_CYCLES = 5000000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       road_det,
  input  logic       count_clr,
  output logic       veh_present,
  output logic       veh_arrive,
  output logic       gap_out,
  output logic       det_fault,
  output logic [7:0] veh_count
);

  localparam logic [CNT_W-1:0] FILT_LAST  = CNT_W'(FILT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [7:0]       COUNT_MAX  = 8'hFF;

  typedef enum logic [1:0] {
    ST_EMPTY_GAP = 2'd0,
    ST_EMPTY     = 2'd1,
    ST_PRESENT   = 2'd2,
    ST_FAULT     = 2'd3
  } state_e;

  // Two-flop synchroniser; sync_q[1] is the only version of road_det used downstream.
  logic [1:0]       sync_q, sync_d;
  logic             det_s;

  logic             det_f_q, det_f_d;
  logic [CNT_W-1:0] filt_cnt_q, filt_cnt_d;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] stuck_cnt_q, stuck_cnt_d;
  logic             arrive_d;
  logic [7:0]       count_q, count_d;

  logic             present_q, arrive_q, gap_q, fault_q;

  assign sync_d = {sync_q[0], road_det};
  assign det_s  = sync_q[1];

  always_comb begin
    det_f_d    = det_f_q;
    filt_cnt_d = filt_cnt_q;
    if (det_s == det_f_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FILT_LAST) begin
      det_f_d    = det_s;
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + CNT_ONE;
    end
  end

  // The FSM reacts to the accepted level; while empty a high det_f is by construction a new rise.
  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    stuck_cnt_d = stuck_cnt_q;
    arrive_d    = 1'b0;
    case (state_q)
      ST_EMPTY_GAP: begin
        if (det_f_q) begin
          state_d     = ST_PRESENT;
          arrive_d    = 1'b1;
          stuck_cnt_d = '0;
        end
      end
      ST_EMPTY: begin
        if (det_f_q) begin
          state_d     = ST_PRESENT;
          arrive_d    = 1'b1;
          stuck_cnt_d = '0;
        end else if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_EMPTY_GAP;
        end else begin
          gap_cnt_d = gap_cnt_q + CNT_ONE;
        end
      end
      ST_PRESENT: begin
        if (!det_f_q) begin
          state_d   = ST_EMPTY;
          gap_cnt_d = '0;
        end else if (stuck_cnt_q == STUCK_LAST) begin
          state_d = ST_FAULT;
        end else begin
          stuck_cnt_d = stuck_cnt_q + CNT_ONE;
        end
      end
      ST_FAULT: begin
        // Leaving FAULT always passes through EMPTY so a recovered loop must re-arrive.
        if (!det_f_q) begin
          state_d   = ST_EMPTY;
          gap_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_EMPTY_GAP;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (count_clr) begin
      count_d = arrive_d ? 8'd1 : 8'd0;
    end else if (arrive_d && (count_q != COUNT_MAX)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync_q      <= '0;
      det_f_q     <= 1'b0;
      filt_cnt_q  <= '0;
      state_q     <= ST_EMPTY_GAP;
      gap_cnt_q   <= '0;
      stuck_cnt_q <= '0;
      count_q     <= '0;
      present_q   <= 1'b0;
      arrive_q    <= 1'b0;
      gap_q       <= 1'b1;
      fault_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      det_f_q     <= det_f_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      stuck_cnt_q <= stuck_cnt_d;
      count_q     <= count_d;
      present_q   <= (state_d == ST_PRESENT);
      arrive_q    <= arrive_d;
      gap_q       <= (state_d == ST_EMPTY_GAP);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign veh_present = present_q;
  assign veh_arrive  = arrive_q;
  assign gap_out     = gap_q;
  assign det_fault   = fault_q;
  assign veh_count   = count_q;

endmodule

// File: tb/tb_road_det_qualifier.sv
// Bench for road_det_qualifier: directed timing steps plus randomized runs, all checked
// every clock against a timestamp-based reference model.
module tb_road_det_qualifier;

  localparam int FILT  = 4;
  localparam int GAP   = 10;
  localparam int STUCK = 20;

  localparam int S_EG = 0;
  localparam int S_E  = 1;
  localparam int S_P  = 2;
  localparam int S_F  = 3;

  logic       clk = 1'b0;
  logic       nrst;
  logic       road_det;
  logic       count_clr;
  logic       veh_present;
  logic       veh_arrive;
  logic       gap_out;
  logic       det_fault;
  logic [7:0] veh_count;

  int vectors    = 0;
  int miscompares = 0;

  // reference model state (values after the most recent edge)
  int m_cyc  = 0;
  bit m_s1   = 0;
  bit m_s2   = 0;
  bit m_detf = 0;
  int m_run  = 0;
  int m_st   = S_EG;
  int m_tent = 0;
  bit m_arr  = 0;
  int m_cnt  = 0;

  road_det_qualifier #(
    .FILT_CYCLES (FILT),
    .GAP_CYCLES  (GAP),
    .STUCK_CYCLES(STUCK),
    .CNT_W       (32)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .road_det   (road_det),
    .count_clr  (count_clr),
    .veh_present(veh_present),
    .veh_arrive (veh_arrive),
    .gap_out    (gap_out),
    .det_fault  (det_fault),
    .veh_count  (veh_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: got %0d want %0d (vector %0d)", tag, got, want, vectors);
    end
  endtask

  // One clock of the model: the road is empty until the accepted level has been high, a
  // state's age is measured from the edge it was entered, and inputs pass two sync stages.
  task automatic model_step();
    m_cyc++;
    if (!nrst) begin
      m_s1 = 0; m_s2 = 0; m_detf = 0; m_run = 0;
      m_st = S_EG; m_tent = m_cyc; m_arr = 0; m_cnt = 0;
      return;
    end
    m_arr = 0;
    case (m_st)
      S_EG: if (m_detf) begin m_st = S_P; m_tent = m_cyc; m_arr = 1; end
      S_E: begin
        if (m_detf) begin m_st = S_P; m_tent = m_cyc; m_arr = 1; end
        else if (m_cyc - m_tent == GAP) m_st = S_EG;
      end
      S_P: begin
        if (!m_detf) begin m_st = S_E; m_tent = m_cyc; end
        else if (m_cyc - m_tent == STUCK) m_st = S_F;
      end
      default: if (!m_detf) begin m_st = S_E; m_tent = m_cyc; end
    endcase
    if (count_clr) m_cnt = m_arr ? 1 : 0;
    else if (m_arr) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    if (m_s2 != m_detf) begin
      m_run++;
      if (m_run == FILT) begin m_detf = m_s2; m_run = 0; end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = road_det;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    vectors++;
    chk("veh_present", 32'(veh_present), 32'(m_st == S_P));
    chk("gap_out",     32'(gap_out),     32'(m_st == S_EG));
    chk("det_fault",   32'(det_fault),   32'(m_st == S_F));
    chk("veh_arrive",  32'(veh_arrive),  32'(m_arr));
    chk("veh_count",   32'(veh_count),   32'(m_cnt));
  endtask

  initial begin
    int n;
    int len;

    // 1. reset held with the loop occupied
    nrst = 1'b0; road_det = 1'b1; count_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_present", 32'(veh_present), 32'd0);
      chk("rst_gap", 32'(gap_out), 32'd1);
      chk("rst_count", 32'(veh_count), 32'd0);
    end
    nrst = 1'b1;
    tick();
    chk("post_rst_present", 32'(veh_present), 32'd0);
    chk("post_rst_gap", 32'(gap_out), 32'd1);
    road_det = 1'b0;
    repeat (12) tick();
    $display("step 1: reset done");

    // 2. clean arrival latency
    road_det = 1'b1;
    n = 0;
    do begin tick(); n++; end while (veh_present !== 1'b1 && n < 40);
    chk("arrive_latency", 32'(n), 32'd7);
    chk("arrive_pulse", 32'(veh_arrive), 32'd1);
    chk("arrive_gap", 32'(gap_out), 32'd0);
    chk("arrive_count", 32'(veh_count), 32'd1);
    tick();
    chk("arrive_single", 32'(veh_arrive), 32'd0);
    $display("step 2: clean arrival done");

    // 4a. vehicle leaves, gap timing
    road_det = 1'b0;
    n = 0;
    do begin tick(); n++; end while (veh_present !== 1'b0 && n < 40);
    chk("leave_latency", 32'(n), 32'd7);
    n = 0;
    do begin tick(); n++; end while (gap_out !== 1'b1 && n < 40);
    chk("gap_latency", 32'(n), 32'd10);
    $display("step 4a: gap timing done");

    // 3. three-cycle glitch is ignored
    road_det = 1'b1;
    repeat (3) tick();
    road_det = 1'b0;
    repeat (10) tick();
    chk("glitch_present", 32'(veh_present), 32'd0);
    chk("glitch_count", 32'(veh_count), 32'd1);
    $display("step 3: glitch done");

    // 4b. re-arrival on the last gap clock beats gap expiry
    road_det = 1'b1;
    n = 0;
    do begin tick(); n++; end while (veh_present !== 1'b1 && n < 40);
    chk("rearm_latency", 32'(n), 32'd7);
    road_det = 1'b0;
    repeat (10) tick();
    road_det = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("race_gap_low", 32'(gap_out), 32'd0);
    end
    chk("race_present", 32'(veh_present), 32'd1);
    chk("race_count", 32'(veh_count), 32'd3);
    $display("step 4b: rise/gap race done");

    // 5. stuck loop and recovery
    n = 0;
    do begin tick(); n++; end while (det_fault !== 1'b1 && n < 60);
    chk("stuck_latency", 32'(n), 32'd20);
    chk("stuck_present", 32'(veh_present), 32'd0);
    road_det = 1'b0;
    n = 0;
    do begin tick(); n++; end while (det_fault !== 1'b0 && n < 40);
    chk("fault_exit_latency", 32'(n), 32'd7);
    chk("fault_exit_gap", 32'(gap_out), 32'd0);
    chk("fault_exit_present", 32'(veh_present), 32'd0);
    n = 0;
    do begin tick(); n++; end while (gap_out !== 1'b1 && n < 40);
    chk("fault_gap_latency", 32'(n), 32'd10);
    $display("step 5: stuck loop done");

    // 6. saturation with randomized on/off lengths
    for (int a = 0; a < 256; a++) begin
      road_det = 1'b1;
      len = $urandom_range(4, 8);
      repeat (len) tick();
      road_det = 1'b0;
      len = $urandom_range(4, 8);
      repeat (len) tick();
    end
    repeat (10) tick();
    chk("sat_count", 32'(veh_count), 32'd255);
    road_det = 1'b1;
    repeat (6) tick();
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    chk("clr_arrive_pulse", 32'(veh_arrive), 32'd1);
    chk("clr_arrive_count", 32'(veh_count), 32'd1);
    repeat (3) tick();
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    chk("clr_alone_count", 32'(veh_count), 32'd0);
    road_det = 1'b0;
    repeat (12) tick();
    $display("step 6: counter done");

    // random runs including glitches, stuck periods, clears and resets
    for (int r = 0; r < 150; r++) begin
      road_det = ~road_det;
      len = $urandom_range(1, 30);
      for (int k = 0; k < len; k++) begin
        count_clr = ($urandom_range(0, 15) == 0);
        nrst = ($urandom_range(0, 299) != 0);
        tick();
      end
    end
    nrst = 1'b1; count_clr = 1'b0;
    $display("random phase done");

    // reset while in FAULT
    road_det = 1'b1;
    n = 0;
    do begin tick(); n++; end while (det_fault !== 1'b1 && n < 80);
    chk("fault_reached", 32'(det_fault), 32'd1);
    nrst = 1'b0;
    tick();
    chk("fault_rst_fault", 32'(det_fault), 32'd0);
    chk("fault_rst_gap", 32'(gap_out), 32'd1);
    chk("fault_rst_count", 32'(veh_count), 32'd0);
    nrst = 1'b1;
    road_det = 1'b0;
    repeat (5) tick();
    $display("reset in fault done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
